// File: rtl/rggen_rtl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rggen_rtl_pkg                                                              |
// | Shared types and helpers for the register-block host adapter.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package rggen_rtl_pkg;

  localparam int RGGEN_MAX_BUS_WIDTH    = 1024;
  localparam int RGGEN_MAX_STROBE_WIDTH = RGGEN_MAX_BUS_WIDTH / 8;

  typedef enum logic [1:0] {
    OKAY        = 2'b00,
    SLAVE_ERROR = 2'b10
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } rggen_adapter_state;

  // Widest supported bus; callers size-cast the argument and the result.
  function automatic logic [RGGEN_MAX_BUS_WIDTH-1:0] rggen_expand_strobe(
    input logic [RGGEN_MAX_STROBE_WIDTH-1:0] byte_strobe
  );
    logic [RGGEN_MAX_BUS_WIDTH-1:0] strobe;
    for (int i = 0; i < RGGEN_MAX_BUS_WIDTH; i++) begin
      strobe[i] = byte_strobe[i/8];
    end
    return strobe;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rggen_adapter_response_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rggen_adapter_response_mux                                                 |
// | Folds per-register active/ready/status/read data into one access result.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rggen_adapter_response_mux
  import rggen_rtl_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int REGISTERS = 1
)(
  input  logic [REGISTERS-1:0]           i_active,
  input  logic [REGISTERS-1:0]           i_ready,
  input  logic [2*REGISTERS-1:0]         i_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_read_data,
  output logic                           o_hit,
  output logic                           o_multi_hit,
  output logic                           o_miss,
  output logic [1:0]                     o_status,
  output logic [BUS_WIDTH-1:0]           o_read_data
);

  logic                 w_any;
  logic                 w_multi;
  logic                 w_done;
  logic [1:0]           w_status;
  logic [BUS_WIDTH-1:0] w_data;

  // OR-mux: status and data are only meaningful when exactly one register is active.
  always_comb begin
    w_any    = 1'b0;
    w_multi  = 1'b0;
    w_done   = 1'b0;
    w_status = '0;
    w_data   = '0;
    for (int k = 0; k < REGISTERS; k++) begin
      if (i_active[k]) begin
        w_multi  = w_multi | w_any;
        w_any    = 1'b1;
        w_done   = w_done | i_ready[k];
        w_status = w_status | i_status[2*k+:2];
        w_data   = w_data | i_read_data[BUS_WIDTH*k+:BUS_WIDTH];
      end
    end
  end

  assign o_hit       = w_done;
  assign o_multi_hit = w_multi;
  assign o_miss      = !w_any;
  assign o_status    = w_status;
  assign o_read_data = w_data;

endmodule
`default_nettype wire

// File: rtl/rggen_simple_bus_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rggen_simple_bus_adapter                                                   |
// | Valid/ready host front end broadcasting one access at a time to registers.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rggen_simple_bus_adapter
  import rggen_rtl_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH     = 8,
  parameter int                     BUS_WIDTH         = 32,
  parameter int                     REGISTERS         = 1,
  parameter bit [ADDRESS_WIDTH-1:0] BASE_ADDRESS      = '0,
  parameter int                     BYTE_SIZE         = 256,
  parameter bit                     ERROR_STATUS      = 1'b0,
  parameter bit [BUS_WIDTH-1:0]     DEFAULT_READ_DATA = '0,
  parameter int                     TIMEOUT_CYCLES    = 0
)(
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic                           i_req_write,
  input  logic [ADDRESS_WIDTH-1:0]       i_req_address,
  input  logic [BUS_WIDTH-1:0]           i_req_write_data,
  input  logic [BUS_WIDTH/8-1:0]         i_req_byte_strobe,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [1:0]                     o_rsp_status,
  output logic [BUS_WIDTH-1:0]           o_rsp_read_data,
  output logic                           o_reg_valid,
  output logic                           o_reg_write,
  output logic [ADDRESS_WIDTH-1:0]       o_reg_address,
  output logic [BUS_WIDTH-1:0]           o_reg_write_data,
  output logic [BUS_WIDTH-1:0]           o_reg_strobe,
  input  logic [REGISTERS-1:0]           i_reg_active,
  input  logic [REGISTERS-1:0]           i_reg_ready,
  input  logic [2*REGISTERS-1:0]         i_reg_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_reg_read_data
);

  localparam int                       c_wait_width     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit                       c_timeout_enable = (TIMEOUT_CYCLES > 0);
  localparam logic [c_wait_width-1:0]  c_timeout_last   = c_timeout_enable ? c_wait_width'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [1:0]               c_miss_status    = ERROR_STATUS ? SLAVE_ERROR : OKAY;
  localparam logic [ADDRESS_WIDTH:0]   c_base           = {1'b0, BASE_ADDRESS};
  localparam logic [ADDRESS_WIDTH:0]   c_size           = (ADDRESS_WIDTH + 1)'(BYTE_SIZE);

  rggen_adapter_state        r_state;
  rggen_adapter_state        w_state_next;
  logic [c_wait_width-1:0]   r_wait_count;

  logic                      w_req_ready_next;
  logic                      w_reg_valid_next;
  logic                      w_rsp_valid_next;
  logic                      w_capture;
  logic                      w_rsp_load;
  logic [1:0]                w_rsp_status;
  logic [BUS_WIDTH-1:0]      w_rsp_data;
  logic                      w_wait_clear;
  logic                      w_wait_inc;

  logic                      w_hit;
  logic                      w_multi_hit;
  logic                      w_miss;
  logic [1:0]                w_mux_status;
  logic [BUS_WIDTH-1:0]      w_mux_data;

  logic [ADDRESS_WIDTH+1:0]  w_offset;
  logic                      w_in_range;

  // Extra bits keep BASE_ADDRESS+BYTE_SIZE from wrapping at the top of the space.
  assign w_offset   = {2'b00, i_req_address} - {1'b0, c_base};
  assign w_in_range = !w_offset[ADDRESS_WIDTH+1] && (w_offset[ADDRESS_WIDTH:0] < c_size);

  rggen_adapter_response_mux #(
    .BUS_WIDTH (BUS_WIDTH),
    .REGISTERS (REGISTERS)
  ) u_response_mux (
    .i_active    (i_reg_active),
    .i_ready     (i_reg_ready),
    .i_status    (i_reg_status),
    .i_read_data (i_reg_read_data),
    .o_hit       (w_hit),
    .o_multi_hit (w_multi_hit),
    .o_miss      (w_miss),
    .o_status    (w_mux_status),
    .o_read_data (w_mux_data)
  );

  always_comb begin
    w_state_next     = r_state;
    w_req_ready_next = o_req_ready;
    w_reg_valid_next = o_reg_valid;
    w_rsp_valid_next = o_rsp_valid;
    w_capture        = 1'b0;
    w_rsp_load       = 1'b0;
    w_rsp_status     = OKAY;
    w_rsp_data       = '0;
    w_wait_clear     = 1'b0;
    w_wait_inc       = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready_next = 1'b1;
        if (i_req_valid && o_req_ready) begin
          w_capture        = 1'b1;
          w_wait_clear     = 1'b1;
          w_req_ready_next = 1'b0;
          if (w_in_range) begin
            w_state_next     = ACCESS;
            w_reg_valid_next = 1'b1;
          end else begin
            w_state_next     = RESPOND;
            w_rsp_valid_next = 1'b1;
            w_rsp_load       = 1'b1;
            w_rsp_status     = c_miss_status;
            w_rsp_data       = i_req_write ? '0 : DEFAULT_READ_DATA;
          end
        end
      end
      ACCESS: begin
        w_rsp_load = 1'b1;
        if (w_miss) begin
          w_rsp_status = c_miss_status;
          w_rsp_data   = o_reg_write ? '0 : DEFAULT_READ_DATA;
        end else if (w_multi_hit) begin
          w_rsp_status = SLAVE_ERROR;
        end else if (w_hit) begin
          w_rsp_status = w_mux_status;
          w_rsp_data   = o_reg_write ? '0 : w_mux_data;
        end else if (c_timeout_enable && (r_wait_count == c_timeout_last)) begin
          w_rsp_status = SLAVE_ERROR;
        end else begin
          w_rsp_load = 1'b0;
          w_wait_inc = 1'b1;
        end
        if (w_rsp_load) begin
          w_state_next     = RESPOND;
          w_reg_valid_next = 1'b0;
          w_rsp_valid_next = 1'b1;
        end
      end
      RESPOND: begin
        if (i_rsp_ready) begin
          w_state_next     = IDLE;
          w_rsp_valid_next = 1'b0;
          w_req_ready_next = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= IDLE;
      r_wait_count     <= '0;
      o_req_ready      <= 1'b0;
      o_reg_valid      <= 1'b0;
      o_rsp_valid      <= 1'b0;
      o_reg_write      <= 1'b0;
      o_reg_address    <= '0;
      o_reg_write_data <= '0;
      o_reg_strobe     <= '0;
      o_rsp_status     <= '0;
      o_rsp_read_data  <= '0;
    end else begin
      r_state     <= w_state_next;
      o_req_ready <= w_req_ready_next;
      o_reg_valid <= w_reg_valid_next;
      o_rsp_valid <= w_rsp_valid_next;
      if (w_capture) begin
        o_reg_write      <= i_req_write;
        o_reg_address    <= i_req_address;
        o_reg_write_data <= i_req_write_data;
        o_reg_strobe     <= BUS_WIDTH'(rggen_expand_strobe(RGGEN_MAX_STROBE_WIDTH'(i_req_byte_strobe)));
      end
      if (w_rsp_load) begin
        o_rsp_status    <= w_rsp_status;
        o_rsp_read_data <= w_rsp_data;
      end
      if (w_wait_clear) begin
        r_wait_count <= '0;
      end else if (w_wait_inc && (r_wait_count != '1)) begin
        r_wait_count <= r_wait_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rggen_simple_bus_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rggen_simple_bus_adapter                                                |
// | Directed scoreboard bench; two instances differ only in ERROR_STATUS.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_rggen_simple_bus_adapter;

  localparam int              AW   = 8;
  localparam int              BW   = 32;
  localparam int              NR   = 2;
  localparam logic [AW-1:0]   BASE = 8'h40;
  localparam int              SIZE = 64;
  localparam logic [BW-1:0]   DEF  = 32'hA5A5A5A5;

  typedef struct packed {
    logic [1:0]    status;
    logic [BW-1:0] data;
  } rsp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_write = 1'b0;
  logic [AW-1:0]      req_address = '0;
  logic [BW-1:0]      req_write_data = '0;
  logic [BW/8-1:0]    req_byte_strobe = '0;
  logic               rsp_ready = 1'b0;
  logic [NR-1:0]      reg_active = '0;
  logic [NR-1:0]      reg_ready = '0;
  logic [2*NR-1:0]    reg_status = '0;
  logic [BW*NR-1:0]   reg_read_data = '0;

  logic a_req_ready, a_rsp_valid, a_reg_valid, a_reg_write;
  logic b_req_ready, b_rsp_valid, b_reg_valid, b_reg_write;
  logic [1:0]    a_rsp_status, b_rsp_status;
  logic [BW-1:0] a_rsp_read_data, a_reg_write_data, a_reg_strobe;
  logic [BW-1:0] b_rsp_read_data, b_reg_write_data, b_reg_strobe;
  logic [AW-1:0] a_reg_address, b_reg_address;

  rsp_t q_a[$];
  rsp_t q_b[$];
  int   passed = 0;
  int   total = 0;
  int   ready_delay = 0;
  int   access_cnt = 0;

  always #5 clk = ~clk;

  rggen_simple_bus_adapter #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .REGISTERS(NR), .BASE_ADDRESS(BASE), .BYTE_SIZE(SIZE),
    .ERROR_STATUS(1'b1), .DEFAULT_READ_DATA(DEF), .TIMEOUT_CYCLES(4)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(a_req_ready),
    .i_req_write(req_write), .i_req_address(req_address), .i_req_write_data(req_write_data),
    .i_req_byte_strobe(req_byte_strobe), .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_status(a_rsp_status), .o_rsp_read_data(a_rsp_read_data), .o_reg_valid(a_reg_valid),
    .o_reg_write(a_reg_write), .o_reg_address(a_reg_address), .o_reg_write_data(a_reg_write_data),
    .o_reg_strobe(a_reg_strobe), .i_reg_active(reg_active), .i_reg_ready(reg_ready),
    .i_reg_status(reg_status), .i_reg_read_data(reg_read_data)
  );

  rggen_simple_bus_adapter #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .REGISTERS(NR), .BASE_ADDRESS(BASE), .BYTE_SIZE(SIZE),
    .ERROR_STATUS(1'b0), .DEFAULT_READ_DATA(DEF), .TIMEOUT_CYCLES(4)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(b_req_ready),
    .i_req_write(req_write), .i_req_address(req_address), .i_req_write_data(req_write_data),
    .i_req_byte_strobe(req_byte_strobe), .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_status(b_rsp_status), .o_rsp_read_data(b_rsp_read_data), .o_reg_valid(b_reg_valid),
    .o_reg_write(b_reg_write), .o_reg_address(b_reg_address), .o_reg_write_data(b_reg_write_data),
    .o_reg_strobe(b_reg_strobe), .i_reg_active(reg_active), .i_reg_ready(reg_ready),
    .i_reg_status(reg_status), .i_reg_read_data(reg_read_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Register model: ready rises once the access has lasted more than ready_delay cycles.
  always @(negedge clk) begin
    if (a_reg_valid) access_cnt = access_cnt + 1;
    else access_cnt = 0;
    reg_ready = (access_cnt > ready_delay) ? '1 : '0;
  end

  // Monitor: one scoreboard pop per rising o_rsp_valid of each instance.
  logic seen_a = 1'b0;
  logic seen_b = 1'b0;
  rsp_t exp_a_m, exp_b_m;
  always @(negedge clk) begin
    if (a_rsp_valid && !seen_a) begin
      if (q_a.size() == 0) begin
        total++;
        $display("FAIL a_unexpected_rsp: actual status=%0h data=%0h required none", a_rsp_status, a_rsp_read_data);
      end else begin
        exp_a_m = q_a.pop_front();
        check("a_rsp_status", 64'(a_rsp_status), 64'(exp_a_m.status));
        check("a_rsp_data", 64'(a_rsp_read_data), 64'(exp_a_m.data));
      end
    end
    if (b_rsp_valid && !seen_b) begin
      if (q_b.size() == 0) begin
        total++;
        $display("FAIL b_unexpected_rsp: actual status=%0h data=%0h required none", b_rsp_status, b_rsp_read_data);
      end else begin
        exp_b_m = q_b.pop_front();
        check("b_rsp_status", 64'(b_rsp_status), 64'(exp_b_m.status));
        check("b_rsp_data", 64'(b_rsp_read_data), 64'(exp_b_m.data));
      end
    end
    seen_a = a_rsp_valid;
    seen_b = b_rsp_valid;
  end

  task automatic do_req(input string name, input logic wr, input logic [AW-1:0] addr,
                        input logic [BW-1:0] wdata, input logic [BW/8-1:0] strb,
                        input logic [BW-1:0] exp_strobe, input rsp_t exp_a, input rsp_t exp_b,
                        input int exp_cycles, input int hold);
    int            waited;
    int            n_reg;
    int            lat;
    logic          held_ok;
    logic          stable;
    logic [1:0]    st0;
    logic [BW-1:0] d0;
    q_a.push_back(exp_a);
    q_b.push_back(exp_b);
    waited = 0;
    while (!a_req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_req_ready"}, 64'(a_req_ready), 64'(1));
    req_valid = 1'b1; req_write = wr; req_address = addr;
    req_write_data = wdata; req_byte_strobe = strb;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_address = ~addr; req_write_data = ~wdata; req_byte_strobe = ~strb;
    n_reg = 0; lat = 1; held_ok = 1'b1;
    while (!a_rsp_valid && lat < 40) begin
      if (a_reg_valid) begin
        n_reg++;
        if (a_reg_write_data !== wdata || a_reg_address !== addr ||
            a_reg_write !== wr || a_reg_strobe !== exp_strobe) held_ok = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    check({name, "_reg_cycles"}, 64'(n_reg), 64'(exp_cycles));
    check({name, "_rsp_latency"}, 64'(lat), 64'(exp_cycles + 1));
    check({name, "_reg_held"}, 64'(held_ok), 64'(1));
    st0 = a_rsp_status; d0 = a_rsp_read_data; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      if (!a_rsp_valid || a_req_ready || a_reg_valid ||
          a_rsp_status !== st0 || a_rsp_read_data !== d0) stable = 1'b0;
    end
    check({name, "_rsp_stable"}, 64'(stable), 64'(1));
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, "_after_handshake"}, 64'({a_rsp_valid, a_req_ready}), 64'(2'b01));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs_a", 64'(|{a_req_ready, a_rsp_valid, a_rsp_status, a_rsp_read_data, a_reg_valid,
                                   a_reg_write, a_reg_address, a_reg_write_data, a_reg_strobe}), 64'(0));
    check("reset_outputs_b", 64'(|{b_req_ready, b_rsp_valid, b_rsp_status, b_rsp_read_data, b_reg_valid,
                                   b_reg_write, b_reg_address, b_reg_write_data, b_reg_strobe}), 64'(0));
    rst_n = 1'b1;
    #1 check("ready_before_edge", 64'(a_req_ready), 64'(0));
    @(negedge clk);
    check("ready_after_edge", 64'(a_req_ready), 64'(1));

    reg_read_data = {32'h0BADF00D, 32'hDEADBEEF};
    reg_status = 4'b0000;
    reg_active = 2'b01; ready_delay = 0;
    do_req("rd_hit", 1'b0, 8'h44, 32'h0, 4'hF, 32'hFFFFFFFF,
           {2'b00, 32'hDEADBEEF}, {2'b00, 32'hDEADBEEF}, 1, 0);
    ready_delay = 3;
    do_req("wr_wait", 1'b1, 8'h48, 32'h12345678, 4'b0101, 32'h00FF00FF,
           {2'b00, 32'h0}, {2'b00, 32'h0}, 4, 0);
    reg_active = 2'b10; reg_status = 4'b1000; ready_delay = 0;
    do_req("rd_reg1_err", 1'b0, 8'h7C, 32'h0, 4'b0011, 32'h0000FFFF,
           {2'b10, 32'h0BADF00D}, {2'b10, 32'h0BADF00D}, 1, 5);
    reg_status = 4'b0000; reg_active = 2'b00;
    do_req("rd_no_active", 1'b0, 8'h48, 32'h0, 4'hF, 32'hFFFFFFFF,
           {2'b10, DEF}, {2'b00, DEF}, 1, 0);
    do_req("wr_no_active", 1'b1, 8'h4C, 32'hCAFEF00D, 4'hF, 32'hFFFFFFFF,
           {2'b10, 32'h0}, {2'b00, 32'h0}, 1, 0);
    reg_active = 2'b01;
    do_req("rd_above", 1'b0, 8'h80, 32'h0, 4'hF, 32'hFFFFFFFF,
           {2'b10, DEF}, {2'b00, DEF}, 0, 0);
    do_req("wr_below", 1'b1, 8'h3C, 32'h1, 4'hF, 32'hFFFFFFFF,
           {2'b10, 32'h0}, {2'b00, 32'h0}, 0, 0);
    ready_delay = 1000;
    do_req("rd_timeout", 1'b0, 8'h40, 32'h0, 4'hF, 32'hFFFFFFFF,
           {2'b10, 32'h0}, {2'b10, 32'h0}, 4, 0);
    ready_delay = 3;
    do_req("rd_ready_at_limit", 1'b0, 8'h40, 32'h0, 4'hF, 32'hFFFFFFFF,
           {2'b00, 32'hDEADBEEF}, {2'b00, 32'hDEADBEEF}, 4, 0);
    reg_active = 2'b11; ready_delay = 0;
    do_req("rd_multi", 1'b0, 8'h50, 32'h0, 4'hF, 32'hFFFFFFFF,
           {2'b10, 32'h0}, {2'b10, 32'h0}, 1, 0);

    // Reset during ACCESS: the pending request must vanish without a response.
    reg_active = 2'b01; ready_delay = 1000;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_address = 8'h44;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_in_access", 64'(a_reg_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs_a", 64'(|{a_req_ready, a_rsp_valid, a_rsp_status, a_rsp_read_data, a_reg_valid,
                                     a_reg_write, a_reg_address, a_reg_write_data, a_reg_strobe}), 64'(0));
    check("rst_mid_outputs_b", 64'(|{b_req_ready, b_rsp_valid, b_rsp_status, b_rsp_read_data, b_reg_valid,
                                     b_reg_write, b_reg_address, b_reg_write_data, b_reg_strobe}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_rel_ready_low", 64'(a_req_ready), 64'(0));
    @(negedge clk);
    check("rst_rel_ready_high", 64'(a_req_ready), 64'(1));

    ready_delay = 0;
    do_req("rd_after_reset", 1'b0, 8'h44, 32'h0, 4'hF, 32'hFFFFFFFF,
           {2'b00, 32'hDEADBEEF}, {2'b00, 32'hDEADBEEF}, 1, 0);

    repeat (3) @(negedge clk);
    check("queue_a_empty", 64'(q_a.size()), 64'(0));
    check("queue_b_empty", 64'(q_b.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
